// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: default vectors, fetch FSM encoding, redirect bundle.
// Pure declarations; no latency or backpressure of its own.
package mips_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_HOLD,
    FS_DISCARD
  } fetchState_e;

  typedef struct packed {
    logic        kill;
    logic [31:0] killTgt;
    logic [31:0] acceptTgt;
  } redirect_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Priority select of the next fetch address: interrupt > eret > branch/pending branch > pc+4.
// Purely combinational, zero latency; applies no backpressure.
module fetch_redirect_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic        int_req,
  input  logic        int_back,
  input  logic [31:0] epc,
  input  logic        flush_pc,
  input  logic [31:0] npc,
  input  logic        brPend,
  input  logic [31:0] tgtQ,
  input  logic [31:0] pcPlus4,
  output redirect_t   redirect
);

  always_comb begin
    redirect = '0;
    redirect.kill    = int_req | int_back;
    redirect.killTgt = int_req ? INT_VECTOR : epc;
    // a branch resolving this cycle supersedes one still waiting for its delay slot
    if (flush_pc) begin
      redirect.acceptTgt = npc;
    end else if (brPend) begin
      redirect.acceptTgt = tgtQ;
    end else begin
      redirect.acceptTgt = pcPlus4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC and drives the IM req/ready port, holding the fetched word while decode stalls.
// Latency: word visible on instr_f in the cycle imem_ready rises; next address issued the cycle after accept.
// Backpressure: stall parks the word in a holding register and drops imem_req until decode loads it.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_pc,
  input  logic [31:0] npc,
  input  logic        int_req,
  input  logic        int_back,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic        instr_valid_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic [31:0] pc_plus8_f
);

  fetchState_e state, nextState;
  logic [31:0] pcQ, pcD;
  logic [31:0] tgtQ, tgtD;
  logic [31:0] holdQ, holdD;
  logic        brPend, brPendD;
  redirect_t   redirect;

  assign pc_f       = pcQ;
  assign imem_addr  = pcQ;
  assign pc_plus4_f = pcQ + 32'd4;
  assign pc_plus8_f = pcQ + 32'd8;

  fetch_redirect_sel #(
    .INT_VECTOR (INT_VECTOR)
  ) u_redirect (
    .int_req   (int_req),
    .int_back  (int_back),
    .epc       (epc),
    .flush_pc  (flush_pc),
    .npc       (npc),
    .brPend    (brPend),
    .tgtQ      (tgtQ),
    .pcPlus4   (pc_plus4_f),
    .redirect  (redirect)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FS_IDLE;
      pcQ    <= RESET_PC;
      tgtQ   <= '0;
      holdQ  <= '0;
      brPend <= 1'b0;
    end else begin
      state  <= nextState;
      pcQ    <= pcD;
      tgtQ   <= tgtD;
      holdQ  <= holdD;
      brPend <= brPendD;
    end
  end

  always_comb begin
    nextState     = state;
    pcD           = pcQ;
    tgtD          = tgtQ;
    holdD         = holdQ;
    brPendD       = brPend;
    imem_req      = 1'b0;
    instr_valid_f = 1'b0;
    instr_f       = '0;

    case (state)
      FS_IDLE: begin
        nextState = FS_FETCH;
      end

      FS_FETCH: begin
        imem_req      = 1'b1;
        instr_valid_f = imem_ready;
        instr_f       = imem_rdata;
        if (redirect.kill) begin
          brPendD = 1'b0;
          // an unanswered request cannot be withdrawn, so remember where to go once it lands
          if (imem_ready) begin
            pcD = redirect.killTgt;
          end else begin
            tgtD      = redirect.killTgt;
            nextState = FS_DISCARD;
          end
        end else if (imem_ready && !stall) begin
          pcD     = redirect.acceptTgt;
          brPendD = 1'b0;
        end else if (imem_ready) begin
          holdD     = imem_rdata;
          nextState = FS_HOLD;
        end else if (flush_pc && !stall) begin
          // delay slot still outstanding: park the branch target until it is accepted
          tgtD    = npc;
          brPendD = 1'b1;
        end
      end

      FS_HOLD: begin
        instr_valid_f = 1'b1;
        instr_f       = holdQ;
        if (redirect.kill) begin
          pcD       = redirect.killTgt;
          brPendD   = 1'b0;
          nextState = FS_FETCH;
        end else if (!stall) begin
          pcD       = redirect.acceptTgt;
          brPendD   = 1'b0;
          nextState = FS_FETCH;
        end
      end

      FS_DISCARD: begin
        imem_req = 1'b1;
        if (redirect.kill) begin
          brPendD = 1'b0;
          if (imem_ready) begin
            pcD       = redirect.killTgt;
            nextState = FS_FETCH;
          end else begin
            tgtD = redirect.killTgt;
          end
        end else if (imem_ready) begin
          pcD       = tgtQ;
          nextState = FS_FETCH;
        end
      end

      default: begin
        nextState = FS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table of per-cycle stimulus and expected outputs for fetch_sequencer, plus hand sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush_pc;
  logic [31:0] npc;
  logic        int_req;
  logic        int_back;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic        instr_valid_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_plus8_f;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush_pc      (flush_pc),
    .npc           (npc),
    .int_req       (int_req),
    .int_back      (int_back),
    .epc           (epc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_f       (instr_f),
    .instr_valid_f (instr_valid_f),
    .pc_f          (pc_f),
    .pc_plus4_f    (pc_plus4_f),
    .pc_plus8_f    (pc_plus8_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic [31:0] n;
    logic        ir;
    logic        ib;
    logic [31:0] e;
    logic        rdy;
    logic [31:0] rd;
    logic        xReq;
    logic        xVld;
    logic [31:0] xIns;
    logic [31:0] xPc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] n,
                              input logic ir, input logic ib, input logic [31:0] e,
                              input logic rdy, input logic [31:0] rd,
                              input logic xReq, input logic xVld, input logic [31:0] xIns,
                              input logic [31:0] xPc);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.n = n; v.ir = ir; v.ib = ib; v.e = e;
    v.rdy = rdy; v.rd = rd; v.xReq = xReq; v.xVld = xVld; v.xIns = xIns; v.xPc = xPc;
    return v;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, got, exp);
    end
  endtask

  // drive on the falling edge, check combinational outputs 1ns later, state advances on the next rise
  task automatic applyVec(input vec_t v, input string tag);
    @(negedge clk);
    reset      = v.r;
    stall      = v.s;
    flush_pc   = v.f;
    npc        = v.n;
    int_req    = v.ir;
    int_back   = v.ib;
    epc        = v.e;
    imem_ready = v.rdy;
    imem_rdata = v.rd;
    #1;
    cmp(tag, "imem_req", {31'd0, imem_req}, {31'd0, v.xReq});
    cmp(tag, "instr_valid_f", {31'd0, instr_valid_f}, {31'd0, v.xVld});
    cmp(tag, "instr_f", instr_f, v.xIns);
    cmp(tag, "pc_f", pc_f, v.xPc);
    cmp(tag, "pc_plus4_f", pc_plus4_f, v.xPc + 32'd4);
    cmp(tag, "pc_plus8_f", pc_plus8_f, v.xPc + 32'd8);
    if (v.xReq) cmp(tag, "imem_addr", imem_addr, v.xPc);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush_pc = 1'b0; npc = '0;
    int_req = 1'b0; int_back = 1'b0; epc = '0; imem_ready = 1'b0; imem_rdata = '0;

    //             r s f npc           ir ib epc          rdy rdata          req vld instr          pc
    // reset, release, reset again mid-FETCH, release
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0000_3000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0000_3000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3000));
    vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0000_3000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0000_3000));
    // streaming, one word per cycle
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0000,1, 1, 32'h1000_0000,32'h0000_3000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0001,1, 1, 32'h1000_0001,32'h0000_3004));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0002,1, 1, 32'h1000_0002,32'h0000_3008));
    // stall on arrival -> HOLD keeps the word while rdata wanders
    vecs.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1, 32'hAABB_CCDD,1, 1, 32'hAABB_CCDD,32'h0000_300C));
    vecs.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        0, 32'h1234_5678,0, 1, 32'hAABB_CCDD,32'h0000_300C));
    vecs.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1, 32'h8765_4321,0, 1, 32'hAABB_CCDD,32'h0000_300C));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        0, 1, 32'hAABB_CCDD,32'h0000_300C));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0003,1, 1, 32'h1000_0003,32'h0000_3010));
    // branch with delay slot accepted the same cycle
    vecs.push_back(mk(1,0,1,32'h0000_3100,0,0,32'h0,        1, 32'h1000_0004,1, 1, 32'h1000_0004,32'h0000_3014));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0005,1, 1, 32'h1000_0005,32'h0000_3100));
    // branch before the delay slot arrives -> pending target
    vecs.push_back(mk(1,0,1,32'h0000_3200,0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3104));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0006,1, 1, 32'h1000_0006,32'h0000_3104));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0007,1, 1, 32'h1000_0007,32'h0000_3200));
    // interrupt with request outstanding -> DISCARD for 3 cycles
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3204));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3204));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3204));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'hDEAD_BEEF,1, 0, 32'h0,        32'h0000_3204));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_0008,1, 1, 32'h1000_0008,32'h0000_4180));
    // int_req and int_back together with ready: interrupt wins
    vecs.push_back(mk(1,0,0,32'h0,        1,1,32'h0000_3010,1, 32'h1000_0009,1, 1, 32'h1000_0009,32'h0000_4184));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_4180));
    // eret while holding -> held word dropped, fetch from epc
    vecs.push_back(mk(1,1,0,32'h0,        0,0,32'h0,        1, 32'hCAFE_F00D,1, 1, 32'hCAFE_F00D,32'h0000_4180));
    vecs.push_back(mk(1,1,0,32'h0,        0,1,32'h0000_3010,0, 32'h0,        0, 1, 32'hCAFE_F00D,32'h0000_4180));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_000A,1, 1, 32'h1000_000A,32'h0000_3010));
    // PC wrap at the top of the address space
    vecs.push_back(mk(1,0,1,32'hFFFF_FFFC,0,0,32'h0,        1, 32'h1000_000B,1, 1, 32'h1000_000B,32'h0000_3014));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'hFFFF_FFFC));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h1000_000C,1, 1, 32'h1000_000C,32'hFFFF_FFFC));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_0000));
    // a second kill in DISCARD retargets
    vecs.push_back(mk(1,0,0,32'h0,        1,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_0000));
    vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h0000_3020,0, 32'h0,        1, 0, 32'h0,        32'h0000_0000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        1, 32'h0000_0055,1, 0, 32'h0,        32'h0000_0000));
    vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0000_3020));

    foreach (vecs[i]) applyVec(vecs[i], $sformatf("vec%0d", i));

    // reset while a discarded request is outstanding abandons it
    applyVec(mk(1,0,0,32'h0,0,0,32'h0,0,32'h0,1,0,32'h0,32'h0000_3020),               "rstDisc0");
    applyVec(mk(1,0,0,32'h0,1,0,32'h0,0,32'h0,1,0,32'h0,32'h0000_3020),               "rstDisc1");
    applyVec(mk(0,0,0,32'h0,0,0,32'h0,1,32'h7777_7777,0,0,32'h0,32'h0000_3000),       "rstDisc2");
    applyVec(mk(1,0,0,32'h0,0,0,32'h0,1,32'h7777_7777,0,0,32'h0,32'h0000_3000),       "rstDisc3");
    applyVec(mk(1,0,0,32'h0,0,0,32'h0,1,32'h2000_0000,1,1,32'h2000_0000,32'h0000_3000),"rstDisc4");

    // kill with ready beats stall: no HOLD, refetch from the vector
    applyVec(mk(1,1,0,32'h0,1,0,32'h0,1,32'h2000_0001,1,1,32'h2000_0001,32'h0000_3004),"killStall0");
    applyVec(mk(1,1,0,32'h0,0,0,32'h0,0,32'h0,1,0,32'h0,32'h0000_4180),               "killStall1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
